note_player: RTL and testbench

Consumes note events (octave, note, length, start timestamp) produced by the keyboard capture stage and turns them into an audible square wave on the buzzer pin. Events arrive over a valid/ready handshake and are held until the system timestamp reaches their start time. Each event then plays for a duration set by its length code. The block is the playback end of the note-event interface and sits between the event source (live capture or song ROM) and the buzzer pin.

---
 rtl/note_player_pkg.sv | 47 ++++
 rtl/note_player_tone_gen.sv | 36 +++
 rtl/note_player.sv | 125 ++++++++++++
 tb/tb_note_player.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared constants, state encoding and pitch-table helper for the note-event playback block.
package note_player_pkg;

  localparam int unsigned OCTAVE_BITS = 3;
  localparam int unsigned NOTE_BITS   = 3;
  localparam int unsigned LENGTH_BITS = 3;
  localparam int unsigned CLOCK_BITS  = 32;
  localparam int unsigned COUNT_BITS  = 32;

  localparam logic [NOTE_BITS-1:0]   NOTE_REST  = 3'd7;
  localparam logic [LENGTH_BITS-1:0] LENGTH_MAX = 3'd6;

  // Octave-0 fundamentals in centihertz, C..B
  localparam int unsigned F0_C = 1635;
  localparam int unsigned F0_D = 1835;
  localparam int unsigned F0_E = 2060;
  localparam int unsigned F0_F = 2183;
  localparam int unsigned F0_G = 2450;
  localparam int unsigned F0_A = 2750;
  localparam int unsigned F0_B = 3087;

  typedef enum logic [1:0] {StIdle, StWait, StPlay} state_e;

  // Octave-0 half-period in clk cycles; 0 for the rest code.
  function automatic logic [COUNT_BITS-1:0] half_period0(input longint unsigned clk_hz,
                                                         input logic [NOTE_BITS-1:0] note);
    longint unsigned f0;
    longint unsigned q;
    case (note)
      3'd0:    f0 = 64'(F0_C);
      3'd1:    f0 = 64'(F0_D);
      3'd2:    f0 = 64'(F0_E);
      3'd3:    f0 = 64'(F0_F);
      3'd4:    f0 = 64'(F0_G);
      3'd5:    f0 = 64'(F0_A);
      3'd6:    f0 = 64'(F0_B);
      default: f0 = 64'd0;
    endcase
    if (f0 == 64'd0) begin
      q = 64'd0;
    end else begin
      q = (clk_hz * 64'd100) / (64'd2 * f0);
    end
    return q[COUNT_BITS-1:0];
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// Square-wave generator: toggles every `half` cycles while run is high, phase reset when low.
module tone_gen
  import note_player_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [COUNT_BITS-1:0] half,
  output logic                  wave
);

  logic [COUNT_BITS-1:0] cnt_q;
  logic                  wave_q;
  logic                  wrap;

  // Widened compare so half == 0 degenerates to a toggle every cycle.
  assign wrap = ({1'b0, cnt_q} + {{COUNT_BITS{1'b0}}, 1'b1}) >= {1'b0, half};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (!run) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q  <= cnt_q + {{(COUNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/note_player.sv
// Note-event playback: waits for the start timestamp, then plays a square tone for the length code.
// Define NOTE_PLAYER_ARTIC_EN to silence the last eighth of every note (articulation).
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned WHOLE_CYCLES = 200_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OCTAVE_BITS-1:0] in_octave,
  input  logic [NOTE_BITS-1:0]   in_note,
  input  logic [LENGTH_BITS-1:0] in_length,
  input  logic [CLOCK_BITS-1:0]  in_clock,
  input  logic [CLOCK_BITS-1:0]  system_clock,
  output logic                   buzzer,
  output logic                   busy
);

  localparam logic [COUNT_BITS-1:0] HALF0 [8] = '{
    half_period0(64'(CLK_HZ), 3'd0), half_period0(64'(CLK_HZ), 3'd1),
    half_period0(64'(CLK_HZ), 3'd2), half_period0(64'(CLK_HZ), 3'd3),
    half_period0(64'(CLK_HZ), 3'd4), half_period0(64'(CLK_HZ), 3'd5),
    half_period0(64'(CLK_HZ), 3'd6), half_period0(64'(CLK_HZ), NOTE_REST)
  };
  localparam logic [COUNT_BITS-1:0] WHOLE = COUNT_BITS'(WHOLE_CYCLES);

  state_e                 state_q, state_d;
  logic [OCTAVE_BITS-1:0] octave_q;
  logic [NOTE_BITS-1:0]   note_q;
  logic [LENGTH_BITS-1:0] length_q;
  logic [LENGTH_BITS-1:0] length_eff;
  logic [CLOCK_BITS-1:0]  start_q;
  logic [COUNT_BITS-1:0]  dur_q;
  logic [COUNT_BITS-1:0]  half_q;
  logic                   accept;
  logic                   start_ok;
  logic                   play_done;
  logic                   enter_play;
  logic                   tone_run;
  logic                   wave;
  logic                   mute;

  assign length_eff = (in_length > LENGTH_MAX) ? LENGTH_MAX : in_length;
  assign accept     = in_valid && in_ready;
  assign start_ok   = (start_q == '0) || (system_clock >= start_q);
  assign play_done  = dur_q <= {{(COUNT_BITS-1){1'b0}}, 1'b1};
  assign enter_play = (state_q == StWait) && (state_d == StPlay);

`ifdef NOTE_PLAYER_ARTIC_EN
  logic [COUNT_BITS-1:0] full_dur;
  assign full_dur = WHOLE >> length_q;
  assign mute     = dur_q <= (full_dur >> 3);
`else
  assign mute = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept)    state_d = StWait;
        StWait:  if (start_ok)  state_d = StPlay;
        StPlay:  if (play_done) state_d = StIdle;
        default:                state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == StIdle) && en;
    busy     = state_q != StIdle;
    tone_run = (state_q == StPlay) && (note_q != NOTE_REST);
    buzzer   = tone_run && en && wave && !mute;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      octave_q <= '0;
      note_q   <= '0;
      length_q <= '0;
      start_q  <= '0;
      dur_q    <= '0;
      half_q   <= '0;
    end else begin
      if (accept) begin
        octave_q <= in_octave;
        note_q   <= in_note;
        length_q <= length_eff;
        start_q  <= in_clock;
      end
      if (state_d == StIdle) begin
        dur_q  <= '0;
        half_q <= '0;
      end else if (enter_play) begin
        dur_q  <= WHOLE >> length_q;
        half_q <= HALF0[note_q] >> octave_q;
      end else if (state_q == StPlay) begin
        dur_q  <= dur_q - {{(COUNT_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  tone_gen u_tone_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (tone_run),
    .half (half_q),
    .wave (wave)
  );

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with CLK_HZ=100_000 and WHOLE_CYCLES=1024.
module tb_note_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_octave;
  logic [2:0]  in_note;
  logic [2:0]  in_length;
  logic [31:0] in_clock;
  logic [31:0] system_clock;
  logic        buzzer;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic trace [0:2047];

  typedef struct {
    logic [2:0] oct;
    logic [2:0] note;
    logic [2:0] len;
    int         exp_busy;  // WAIT cycle + PLAY cycles
    int         exp_rise;  // PLAY-relative cycle of first buzzer rise, -1 if none
    int         exp_fall;  // PLAY-relative cycle of first fall, -1 if none
  } vec_t;

  vec_t vecs [9];

  note_player #(
    .CLK_HZ       (100_000),
    .WHOLE_CYCLES (1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_octave    (in_octave),
    .in_note      (in_note),
    .in_length    (in_length),
    .in_clock     (in_clock),
    .system_clock (system_clock),
    .buzzer       (buzzer),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one event, then record buzzer per PLAY cycle until busy drops.
  task automatic run_event(input logic [2:0] o, input logic [2:0] n, input logic [2:0] l,
                           input logic [31:0] c, output int busy_n);
    for (int k = 0; k < 2048; k++) trace[k] = 1'b0;
    in_octave = o;
    in_note   = n;
    in_length = l;
    in_clock  = c;
    in_valid  = 1'b1;
    check("ready_before_offer", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("accepted_busy", busy, 1);
    busy_n = 0;
    while (busy && busy_n < 2000) begin
      if (busy_n >= 1) trace[busy_n-1] = buzzer;
      busy_n++;
      step();
    end
  endtask

  initial begin
    int busy_n;
    int rise;
    int fall;
    int d;
    int hi_tail;
    int hi_head;
    int wait_bad;
    int n;

    vecs[0] = '{3'd4, 3'd5, 3'd2, 257, 113,
`ifdef NOTE_PLAYER_ARTIC_EN
                224};
`else
                226};
`endif
    vecs[1] = '{3'd5, 3'd0, 3'd1, 513, 95, 190};
    vecs[2] = '{3'd7, 3'd6, 3'd3, 129, 12, 24};
    vecs[3] = '{3'd7, 3'd6, 3'd7, 17, 12, -1};
    vecs[4] = '{3'd3, 3'd4, 3'd0, 1025, 255, 510};
    vecs[5] = '{3'd0, 3'd1, 3'd6, 17, -1, -1};
    vecs[6] = '{3'd7, 3'd3, 3'd4, 65, 17, 34};
    vecs[7] = '{3'd3, 3'd7, 3'd3, 129, -1, -1};
    vecs[8] = '{3'd6, 3'd2, 3'd5, 33, -1, -1};

    rst          = 1'b1;
    en           = 1'b1;
    in_valid     = 1'b0;
    in_octave    = '0;
    in_note      = '0;
    in_length    = '0;
    in_clock     = '0;
    system_clock = '0;
    #3;
    check("reset_buzzer", buzzer, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_event(vecs[i].oct, vecs[i].note, vecs[i].len, 32'd0, busy_n);
      d = busy_n - 1;
      rise = -1;
      fall = -1;
      for (int k = 0; k < d && k < 2048; k++) begin
        if (rise < 0 && trace[k]) rise = k;
        else if (rise >= 0 && fall < 0 && !trace[k]) fall = k;
      end
      check($sformatf("v%0d_busy_len", i), busy_n, vecs[i].exp_busy);
      check($sformatf("v%0d_first_rise", i), rise, vecs[i].exp_rise);
      check($sformatf("v%0d_first_fall", i), fall, vecs[i].exp_fall);
      check($sformatf("v%0d_end_buzzer", i), buzzer, 0);
      check($sformatf("v%0d_end_ready", i), in_ready, 1);
    end

    // Articulation: B7, length 2, half 12 -> 16 high cycles in the final 32 when legato.
    run_event(3'd7, 3'd6, 3'd2, 32'd0, busy_n);
    hi_tail = 0;
    hi_head = 0;
    for (int k = 0; k < 224; k++) if (trace[k]) hi_head++;
    for (int k = 224; k < 256; k++) if (trace[k]) hi_tail++;
    check("artic_busy_len", busy_n, 257);
    check("artic_head_sounding", (hi_head > 0) ? 1 : 0, 1);
`ifdef NOTE_PLAYER_ARTIC_EN
    check("artic_tail_high", hi_tail, 0);
`else
    check("legato_tail_high", hi_tail, 16);
`endif

    // Scheduled start at timestamp 600.
    step();
    system_clock = 32'd500;
    in_octave    = 3'd7;
    in_note      = 3'd6;
    in_length    = 3'd6;
    in_clock     = 32'd600;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    wait_bad = 0;
    for (int s = 500; s < 600; s++) begin
      system_clock = s;
      step();
      if (!busy || buzzer) wait_bad++;
    end
    check("sched_wait_hold", wait_bad, 0);
    system_clock = 32'd600;
    n    = 0;
    rise = -1;
    while (busy && n < 200) begin
      step();
      n++;
      if (buzzer && rise < 0) rise = n;
    end
    check("sched_first_rise", rise, 13);
    check("sched_end", n, 17);
    system_clock = 32'd0;

    // Abort by dropping en mid-tone.
    step();
    in_octave = 3'd7;
    in_note   = 3'd6;
    in_length = 3'd0;
    in_clock  = 32'd0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("abort_pre_tone", buzzer, 1);
    en = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_buzzer", buzzer, 0);
    check("abort_ready_low", in_ready, 0);
    step();
    en = 1'b1;
    #1;
    check("abort_ready_back", in_ready, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy) n++;
    end
    check("abort_no_replay", n, 0);

    // Asynchronous reset in the middle of a sounding note.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("reset_pre_tone", buzzer, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midplay_reset_buzzer", buzzer, 0);
    check("midplay_reset_busy", busy, 0);
    check("midplay_reset_ready", in_ready, 1);
    step();
    rst = 1'b0;
    step();
    check("post_reset_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
